lsu_dmem_if: RTL and testbench
==============================

Name: lsu_dmem_if

Overview:
- Load/store initiator that drives the data-memory port: en, wr, addr, wdata, wstrb → rdata.
- Accepts one load/store from the execute stage over a valid/ready handshake.
- Word-aligns the address and lane-aligns store data and byte strobes.
- Performs a single registered memory access, then returns sign- or zero-extended load data over a valid/ready response channel.
- Sits between the EX/MEM pipeline register and the DPI-backed data memory.

Parameters:
- WAIT_CYCLES, 0, extra idle cycles inserted before the access cycle to emulate memory latency (0..15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  pipeline presents a memory op
- req_ready  output  1  block can accept an op
- req_wr  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  zero-extend loads (lbu/lhu)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  result available
- resp_ready  input  1  pipeline consumes result
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_misalign  output  1  access was misaligned or size was reserved; no memory access performed
- mem_en  output  1  memory enable
- mem_wr  output  1  memory write
- mem_addr  output  32  word-aligned address
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte strobes
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_misalign = 0; mem_en = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture wr, size, unsigned, addr[1:0], addr and wdata.
  - If misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size=11): go to RESP with resp_misalign = 1, resp_rdata = 0. No mem_en is issued.
  - Otherwise go to WAIT if WAIT_CYCLES > 0, else go to ACCESS.
- WAIT: a 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0, go to ACCESS.
- ACCESS:
  - Exactly one cycle. mem_en = 1, and mem_wr/mem_addr/mem_wdata/mem_wstrb are stable from registers. Memory must see each store exactly once.
  - mem_rdata is sampled at the end of the cycle, extracted, and extended into resp_rdata.
  - Next state is RESP.
- mem_* outside ACCESS: mem_en = 0 and mem_wr = 0. Address and data may hold their last values.
- RESP:
  - resp_valid = 1 and req_ready = 0.
  - When resp_ready = 1: go to IDLE and deassert resp_valid next cycle.
  - No back-to-back accept in the same cycle as the response handshake, so throughput is at most one op per 3 cycles.
- Store alignment, with o = addr[1:0]:
  - Byte: mem_wdata = {4{wdata[7:0]}}, mem_wstrb = 4'b0001 << o.
  - Half: mem_wdata = {2{wdata[15:0]}}, mem_wstrb = 4'b0011 << o.
  - Word: mem_wdata = wdata, mem_wstrb = 4'b1111.
- Load extraction:
  - Byte = mem_rdata[8*o +: 8]; half = mem_rdata[8*o +: 16].
  - Sign-extend unless req_unsigned. req_unsigned is ignored for word loads.
- Stores return resp_rdata = 0 and resp_misalign = 0.
- mem_addr = {addr[31:2], 2'b00}.
- Reset mid-operation (WAIT/ACCESS/RESP): abort immediately to IDLE with all outputs at reset values. A pending store in ACCESS may or may not have reached memory; the bench must not check it.
- req_valid while busy is ignored, since req_ready = 0. The requester must hold the op until the handshake.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_B/SZ_H/SZ_W.
  - FSM state typedef (IDLE/WAIT/ACCESS/RESP).
  - Strobe base constants.
- Sub-module lsu_align: purely combinational. Store lane replication and strobe generation, misalign detect, and load extract/extend. The FSM, counter and capture registers remain in lsu_dmem_if.

Test Plan:
- sw addr 0x8000_0004 data 0xDEADBEEF → one ACCESS cycle with mem_addr 0x8000_0004, wstrb 1111, wdata 0xDEADBEEF; then resp_valid with rdata 0.
- sb addr 0x8000_0007 data 0x1234_56A5 → mem_addr 0x8000_0004, wstrb 1000, wdata 0xA5A5A5A5; exactly one mem_en cycle.
- lb addr 0x8000_0006 with mem_rdata 0x0080_0000 → resp_rdata 0xFFFF_FF80; lbu at the same address → 0x0000_0080.
- lh addr 0x8000_0003 → resp_misalign 1, rdata 0, mem_en never asserted; size=11 → same result.
- WAIT_CYCLES=3: lw issued at cycle t → mem_en high only at t+4, resp_valid from t+5. With resp_ready held low for 5 cycles, resp_valid and rdata stay stable and req_ready stays 0.
- Assert rst during WAIT of a sw → outputs return to reset values asynchronously; the next lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit data-memory interface.
// Access sizes, FSM state constants and byte-strobe bases.
package lsu_pkg;

    localparam logic [1:0] SZ_B    = 2'b00;
    localparam logic [1:0] SZ_H    = 2'b01;
    localparam logic [1:0] SZ_W    = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_WAIT   = 2'd1;
    localparam lsu_state_t ST_ACCESS = 2'd2;
    localparam lsu_state_t ST_RESP   = 2'd3;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes and misalign detect on the
// incoming request, load extraction/extension on the captured op.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_req_size,
    input  logic [1:0]  i_req_off,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_rdata,
    output logic        o_misalign,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_wstrb,
    output logic [31:0] o_ld_data
);

    logic [15:0] w_ld_half;
    logic [7:0]  w_ld_byte;

    assign w_ld_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    assign w_ld_byte = i_ld_off[0] ? w_ld_half[15:8] : w_ld_half[7:0];

    always_comb begin
        o_misalign = 1'b0;
        o_st_wdata = i_req_wdata;
        o_st_wstrb = STRB_W;
        case (i_req_size)
            SZ_B: begin
                o_st_wdata = {4{i_req_wdata[7:0]}};
                o_st_wstrb = STRB_B << i_req_off;
            end
            SZ_H: begin
                o_misalign = i_req_off[0];
                o_st_wdata = {2{i_req_wdata[15:0]}};
                o_st_wstrb = STRB_H << i_req_off;
            end
            SZ_W:    o_misalign = (i_req_off != 2'b00);
            default: o_misalign = 1'b1;
        endcase
    end

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_size)
            SZ_B:    o_ld_data = {{24{~i_ld_unsigned & w_ld_byte[7]}}, w_ld_byte};
            SZ_H:    o_ld_data = {{16{~i_ld_unsigned & w_ld_half[15]}}, w_ld_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_if.sv
// Single-outstanding load/store initiator for the data-memory port: accept, optional
// latency wait, one registered access, then hold the response until consumed.
module lsu_dmem_if
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    lsu_state_t  r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_misalign;

    logic        w_misalign;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_ld_data;

    lsu_align u_align (
        .i_req_size    (req_size),
        .i_req_off     (req_addr[1:0]),
        .i_req_wdata   (req_wdata),
        .i_ld_size     (r_size),
        .i_ld_off      (r_off),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (mem_rdata),
        .o_misalign    (w_misalign),
        .o_st_wdata    (w_st_wdata),
        .o_st_wstrb    (w_st_wstrb),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wr       <= req_wr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[1:0];
                        r_misalign <= w_misalign;
                        r_rdata    <= 32'd0;
                        if (w_misalign) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_addr  <= {req_addr[31:2], 2'b00};
                            r_wdata <= w_st_wdata;
                            r_wstrb <= w_st_wstrb;
                            r_cnt   <= WAIT_INIT;
                            r_state <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= r_wr ? 32'd0 : w_ld_data;
                    r_state <= ST_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Strobe/enable derive from the state register so memory sees exactly one access.
    assign mem_en        = (r_state == ST_ACCESS);
    assign mem_wr        = mem_en & r_wr;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wstrb     = r_wstrb;
    assign req_ready     = (r_state == ST_IDLE);
    assign resp_valid    = (r_state == ST_RESP);
    assign resp_rdata    = r_rdata;
    assign resp_misalign = r_misalign;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Bench for lsu_dmem_if: byte-addressed reference memory model, directed scenarios,
// then randomized loads/stores with latency, stall and strobe checks.
module tb_lsu_dmem_if;
    import lsu_pkg::*;

    localparam int unsigned WC = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int en_total = 0;
    int en_expected = 0;

    logic [31:0] dev_mem [0:15];
    logic [7:0]  ref_b [0:63];
    logic        poke = 1'b0;
    logic [3:0]  poke_idx = 4'd0;
    logic [31:0] poke_val = 32'd0;

    lsu_dmem_if #(.WAIT_CYCLES(WC)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dev_mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (poke) begin
            dev_mem[poke_idx] <= poke_val;
        end else if (mem_en && mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) dev_mem[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (mem_en) en_total <= en_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    task automatic set_word(input int idx, input logic [31:0] val);
        poke     = 1'b1;
        poke_idx = 4'(idx);
        poke_val = val;
        for (int j = 0; j < 4; j++) ref_b[4*idx+j] = val[8*j +: 8];
        @(posedge clk);
        @(negedge clk);
        poke = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_misalign", {31'd0, resp_misalign}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    endtask

    // Entered and left at a negedge; expectations come from byte-level memory rules.
    task automatic op(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold);
        int          off;
        int          n;
        int          base;
        int          en_cnt;
        int          en_k;
        int          resp_k;
        bit          mis;
        bit          seen;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_strb;
        logic [31:0] first_rd;

        off  = int'(addr[1:0]);
        base = int'(addr[5:0]);
        n    = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
        mis  = (sz == SZ_RSVD) || (sz == SZ_H && off % 2 != 0) || (sz == SZ_W && off != 0);
        exp_rd = 32'd0;
        if (!mis && !wr) begin
            for (int j = 0; j < n; j++) exp_rd = exp_rd | (32'(ref_b[base+j]) << (8*j));
            if (n < 4 && !uns && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*n));
        end
        exp_strb = 4'd0;
        exp_wd   = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) exp_strb[i] = 1'b1;
            exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end

        req_wr       = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        en_cnt = 0;
        en_k   = 0;
        resp_k = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (mem_en) begin
                en_cnt++;
                en_k = k;
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_wr", {31'd0, mem_wr}, {31'd0, wr});
                if (wr) begin
                    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
                    check("mem_wdata", mem_wdata, exp_wd);
                end
            end else begin
                check("mem_wr_idle", {31'd0, mem_wr}, 32'd0);
            end
            if (resp_valid) begin
                seen   = 1'b1;
                resp_k = k;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            check("resp_timeout", {31'd0, resp_valid}, 32'd1);
            return;
        end

        check("resp_latency", resp_k, mis ? 32'd1 : 32'(WC + 2));
        check("mem_en_count", en_cnt, mis ? 32'd0 : 32'd1);
        if (!mis) check("mem_en_cycle", en_k, 32'(WC + 1));
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_misalign", {31'd0, resp_misalign}, {31'd0, mis});
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        first_rd = resp_rdata;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_resp_rdata", resp_rdata, first_rd);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_mem_en", {31'd0, mem_en}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);

        if (!mis) en_expected++;
        if (!mis && wr) begin
            for (int j = 0; j < n; j++) ref_b[base+j] = wd[8*j +: 8];
            check("mem_contents", dev_mem[base/4], ref_word(base/4));
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [1:0]  off;
        logic [3:0]  idx;
        int          r;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_size     = SZ_B;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        op(1'b1, SZ_W, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 0);
        op(1'b1, SZ_B, 1'b0, 32'h8000_0007, 32'h1234_56A5, 0);
        set_word(1, 32'h0080_0000);
        op(1'b0, SZ_B, 1'b0, 32'h8000_0006, 32'd0, 0);
        op(1'b0, SZ_B, 1'b1, 32'h8000_0006, 32'd0, 0);
        op(1'b0, SZ_H, 1'b0, 32'h8000_0003, 32'd0, 0);
        op(1'b0, SZ_RSVD, 1'b0, 32'h8000_0000, 32'd0, 0);
        op(1'b0, SZ_W, 1'b0, 32'h8000_0008, 32'd0, 5);
        op(1'b0, SZ_H, 1'b0, 32'h8000_0006, 32'd0, 1);

        // Abort a store while it is still waiting; the following load must be clean.
        req_wr    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h8000_0030;
        req_wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) ref_b[48+j] = dev_mem[12][8*j +: 8];
        op(1'b0, SZ_W, 1'b0, 32'h8000_0014, 32'd0, 0);

        for (int t = 0; t < 60; t++) begin
            r   = $urandom_range(0, 9);
            sz  = (r < 3) ? SZ_B : (r < 6) ? SZ_H : (r < 9) ? SZ_W : SZ_RSVD;
            off = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_H) off[0] = 1'b0;
                if (sz == SZ_W) off = 2'b00;
            end
            idx = 4'($urandom_range(0, 15));
            op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               {26'h200_0000, idx, off}, $urandom, $urandom_range(0, 3));
        end

        @(negedge clk);
        check("mem_en_total", en_total, en_expected);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
